operand_entry: RTL and testbench
================================

// Module: operand_entry
// PURPOSE
//  - Input-side front end for the 4-bit hardware adder: lets the user load operand a,
//    operand b and carry-in one after another from four slide switches and one pushbutton.
//  - Synchronises and debounces the button, then steps an entry FSM on each clean press.
//  - Holds a/b/cin stable for the adder and asserts valid once all three are loaded.
// PARAMETERS
//  - DEBOUNCE_CYCLES  500000  stable-level cycles before a button change is accepted
//                             (10 ms at 50 MHz; set to 4 in simulation)
//  - CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  - clk        in   1  system clock, 50 MHz
//  - reset      in   1  asynchronous, active-high reset
//  - sw         in   4  operand switches, asynchronous to clk
//  - key_n      in   1  entry pushbutton, active-low (0 = pressed), asynchronous to clk
//  - a          out  4  captured operand a, to adder input a
//  - b          out  4  captured operand b, to adder input b
//  - cin        out  1  captured carry-in (sw[0] at the cin step)
//  - valid      out  1  high while a, b and cin are all loaded (state SHOW)
//  - step       out  2  current FSM state encoding, for status LEDs
// BEHAVIOUR
//  - Reset (async assert, released on clk edge): a=0, b=0, cin=0, valid=0, step=LOAD_A.
//    Synchronisers preset to released (key=1). Debounced level=1. Counter=0.
//  - sw and key_n each pass through a 2-flop synchroniser. Total sync latency is 2 cycles.
//  - Debounce:
//      - Counter clears whenever the synced key equals the debounced level.
//      - Otherwise the counter increments.
//      - When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
//      - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
//  - press = 1-cycle pulse when the debounced level goes 1->0. Releases generate nothing.
//  - FSM states: LOAD_A=0, LOAD_B=1, LOAD_C=2, SHOW=3.
//      - LOAD_A + press: a <= synced sw; go to LOAD_B.
//      - LOAD_B + press: b <= synced sw; go to LOAD_C.
//      - LOAD_C + press: cin <= synced sw[0]; go to SHOW.
//      - SHOW + press:   a, b, cin unchanged; valid drops; go to LOAD_A (new entry round).
//  - Register update latency: captures happen in the cycle after the press pulse.
//    valid and step update on that same edge.
//  - a, b and cin change only on their own capture. They hold through every other state,
//    so the adder and displays stay stable.
//  - valid = (state == SHOW), registered.
//  - Switches changing during a press: the value captured is the synced sw in the
//    press-pulse cycle.
//  - Holding the button down gives exactly one press. A new press needs a debounced
//    release first.
//  - Reset mid-debounce or mid-entry: everything returns to reset values. No partial
//    operand is retained.
//  - step is 2 bits, so the encoding fully decodes. No illegal states exist.
// STRUCTURE
//  - Shared package: state localparams LOAD_A/LOAD_B/LOAD_C/SHOW, and the 2-bit
//    state width constant.
//  - One sub-module: key_debounce (synchroniser + counter + falling-edge pulse;
//    params DEBOUNCE_CYCLES, CNT_W). FSM and capture registers stay in operand_entry.
// TESTING (DEBOUNCE_CYCLES=4)
//  - Reset: assert reset mid-sim -> a=0, b=0, cin=0, valid=0, step=0 immediately
//    (asynchronous), before the next clk edge.
//  - Full entry:
//      - sw=4'h9, press -> a=9, step=1.
//      - sw=4'h8, press -> b=8, step=2.
//      - sw=4'h1, press -> cin=1, step=3, valid=1.
//      - Expect adder sum=2 and cout=1.
//  - Bounce: toggle key_n every 2 cycles for 10 cycles, then hold 0 -> exactly one
//    press, one step advance.
//  - Hold: key_n held low for 100 cycles -> step advances once only. Release then
//    press -> advances again.
//  - Wrap: from SHOW, press -> valid=0, step=0, a=9/b=8/cin=1 retained.
//    Next press with sw=4'h3 -> a=3.
//  - Reset mid-entry: in LOAD_C, pulse reset -> step=0, a=0, b=0, valid=0. Next press
//    loads a.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry front end: the entry FSM state
// encoding, which is also driven straight out to the status LEDs.
package operand_entry_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    SHOW   = 2'd3
  } entry_state_t;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Pushbutton conditioning: two-flop synchroniser, stable-level debounce
// counter and a single-cycle pulse on each clean press (debounced 1->0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_meta;
  logic             key_sync;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain; preset to the released level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  // Accept a new level only after it has differed from the current one long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= key_sync;
        cnt   <= '0;
        press <= ~key_sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end for the 4-bit adder: loads a, b and carry-in from
// the slide switches on successive button presses and flags when all are set.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         sw,
  input  logic               key_n,
  output logic [3:0]         a,
  output logic [3:0]         b,
  output logic               cin,
  output logic               valid,
  output logic [STATE_W-1:0] step
);

  entry_state_t state;
  entry_state_t next_state;
  logic [3:0]   sw_meta;
  logic [3:0]   sw_sync;
  logic         press;
  logic         load_a;
  logic         load_b;
  logic         load_c;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_debounce (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

  // Two-flop synchroniser for the switch bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // State register; valid is registered alongside so it tracks step exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_A;
      valid <= 1'b0;
    end else begin
      state <= next_state;
      valid <= (next_state == SHOW);
    end
  end

  // Each clean press advances one step, wrapping from SHOW back to LOAD_A
  always_comb begin
    next_state = state;
    if (press) begin
      unique case (state)
        LOAD_A:  next_state = LOAD_B;
        LOAD_B:  next_state = LOAD_C;
        LOAD_C:  next_state = SHOW;
        SHOW:    next_state = LOAD_A;
        default: next_state = LOAD_A;
      endcase
    end
  end

  // Capture enables: only the operand belonging to the current step is loaded
  always_comb begin
    load_a = 1'b0;
    load_b = 1'b0;
    load_c = 1'b0;
    if (press) begin
      unique case (state)
        LOAD_A:  load_a = 1'b1;
        LOAD_B:  load_b = 1'b1;
        LOAD_C:  load_c = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand registers hold their value until their own step captures again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      cin <= 1'b0;
    end else begin
      if (load_a) a   <= sw_sync;
      if (load_b) b   <= sw_sync;
      if (load_c) cin <= sw_sync[0];
    end
  end

  assign step = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a small entry model feeding a
// scoreboard of expected operand/status values.
module tb_operand_entry;

  logic       clk;
  logic       reset;
  logic [3:0] sw;
  logic       key_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       valid;
  logic [1:0] step;

  typedef struct {
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       valid;
    logic [1:0] step;
  } exp_t;

  exp_t sb[$];

  int vectors;
  int miscompares;

  logic [3:0] m_a;
  logic [3:0] m_b;
  logic       m_cin;
  logic [1:0] m_step;

  operand_entry #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .key_n(key_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .valid(valid),
    .step (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  task automatic modelReset(input string tag);
    exp_t e;
    m_a    = 4'h0;
    m_b    = 4'h0;
    m_cin  = 1'b0;
    m_step = 2'd0;
    e = '{tag, m_a, m_b, m_cin, 1'b0, m_step};
    sb.push_back(e);
  endtask

  task automatic modelPress(input string tag, input logic [3:0] swv);
    exp_t e;
    case (m_step)
      2'd0: begin m_a = swv;      m_step = 2'd1; end
      2'd1: begin m_b = swv;      m_step = 2'd2; end
      2'd2: begin m_cin = swv[0]; m_step = 2'd3; end
      default: m_step = 2'd0;
    endcase
    e = '{tag, m_a, m_b, m_cin, (m_step == 2'd3), m_step};
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    vectors++;
    assert (sb.size() > 0)
    else begin
      miscompares++;
      $error("[TB] FAIL scoreboard: observed empty expected entry");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".a"},     {4'h0, a},     {4'h0, e.a});
      cmp({e.tag, ".b"},     {4'h0, b},     {4'h0, e.b});
      cmp({e.tag, ".cin"},   {7'h0, cin},   {7'h0, e.cin});
      cmp({e.tag, ".valid"}, {7'h0, valid}, {7'h0, e.valid});
      cmp({e.tag, ".step"},  {6'h0, step},  {6'h0, e.step});
    end
  endtask

  // Press with switches at swv; optional bounce before settling low, hold for
  // hold_cycles, scribble the switches while held, then release cleanly.
  task automatic applyStimulus(input string tag, input logic [3:0] swv,
                               input bit bounce, input int hold_cycles);
    logic [1:0] prev;
    bit         changed;
    @(negedge clk);
    sw = swv;
    modelPress(tag, swv);
    repeat (3) @(negedge clk);
    prev = step;
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        if (i % 2 == 0) key_n = ~key_n;
        @(negedge clk);
      end
    end
    key_n   = 1'b0;
    changed = 1'b0;
    for (int i = 0; i < 40 && !changed; i++) begin
      @(negedge clk);
      if (step !== prev) changed = 1'b1;
    end
    vectors++;
    assert (changed)
    else begin
      miscompares++;
      $error("[TB] FAIL %s.advance: observed step %0d expected change from %0d", tag, step, prev);
    end
    sw = ~swv;
    repeat (hold_cycles) @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [4:0] sum;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    sw    = 4'h0;
    key_n = 1'b1;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelReset("reset");
    @(negedge clk);
    checkOutput();

    applyStimulus("load_a9", 4'h9, 1'b0, 4);
    applyStimulus("load_b8", 4'h8, 1'b0, 4);
    applyStimulus("load_c1", 4'h1, 1'b0, 4);

    sum = {1'b0, a} + {1'b0, b} + {4'h0, cin};
    cmp("adder_sum",  {4'h0, sum[3:0]}, 8'h02);
    cmp("adder_cout", {7'h0, sum[4]},   8'h01);

    applyStimulus("wrap",    4'h5, 1'b0, 4);
    applyStimulus("load_a3", 4'h3, 1'b0, 4);
    applyStimulus("bounce",  4'h6, 1'b1, 4);
    applyStimulus("hold",    4'h0, 1'b0, 100);
    applyStimulus("rehold",  4'hA, 1'b0, 4);
    applyStimulus("load_a2", 4'h2, 1'b0, 4);
    applyStimulus("load_b7", 4'h7, 1'b0, 4);

    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    modelReset("async_reset");
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    modelReset("post_reset");
    @(negedge clk);
    checkOutput();

    applyStimulus("load_a4", 4'h4, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
